// File: rtl/staff_frame_buffer.sv
// staff_frame_buffer: 320x180 8-bit frame store for the staff renderer.
// Port A takes the pixel-write stream or the full-frame clear sweep.
// Port B feeds a fixed 4-cycle display pipe. That pipe upscales the image
// 4x onto a 1280x720 raster and maps the colour index to grey RGB.
module staff_frame_buffer #(
   parameter int         FB_WIDTH    = 320,
   parameter int         FB_HEIGHT   = 180,
   parameter int         SCALE_LOG2  = 2,
   parameter logic [7:0] CLEAR_INDEX = 8'hFF,
   parameter logic [7:0] STAFF_INDEX = 8'h94
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [15:0] pix_addr_in,
   input  logic [15:0] pix_data_in,
   input  logic        pix_valid_in,
   input  logic        clear_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        active_draw_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   output logic [23:0] rgb_out,
   output logic        active_draw_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        clearing_out,
   output logic [15:0] drop_count_out,
   output logic [31:0] write_count_out
);

   localparam int          DEPTH     = FB_WIDTH * FB_HEIGHT;
   localparam logic [15:0] DEPTH_W   = 16'(DEPTH);
   localparam logic [15:0] LAST_ADDR = 16'(DEPTH - 1);
   localparam logic [15:0] WIDTH_W   = 16'(FB_WIDTH);
   localparam logic [10:0] H_ACTIVE  = 11'(FB_WIDTH << SCALE_LOG2);
   localparam logic [9:0]  V_ACTIVE  = 10'(FB_HEIGHT << SCALE_LOG2);
   localparam logic [23:0] STAFF_RGB = 24'h949494;
   localparam int          X_W       = 11 - SCALE_LOG2;
   localparam int          Y_W       = 10 - SCALE_LOG2;

   typedef enum logic {
      IDLE,
      CLEAR
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] clear_addr, clear_addr_nxt;

   logic        wr_en;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   logic        accept;
   logic        drop;

   logic [7:0]  mem [0:DEPTH-1];
   logic [15:0] rd_addr;
   logic [7:0]  rd_data;

   logic [X_W-1:0] s1_x;
   logic [Y_W-1:0] s1_y;
   logic           s1_vis, s2_vis, s3_vis;
   logic [3:0]     hsync_sr, vsync_sr, active_sr;

   // FSM state register and clear-sweep address
   // NOTE: clocked blocks use non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state      <= IDLE;
         clear_addr <= '0;
      end else begin
         state      <= state_nxt;
         clear_addr <= clear_addr_nxt;
      end
   end

   // Next-state logic and port-A write selection (pixel stream vs. sweep)
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
      state_nxt      = state;
      clear_addr_nxt = clear_addr;
      wr_en          = 1'b0;
      wr_addr        = pix_addr_in;
      wr_data        = pix_data_in[7:0];
      accept         = 1'b0;
      drop           = 1'b0;
      case (state)
         IDLE: begin
            if (pix_valid_in) begin
               if (pix_addr_in < DEPTH_W) begin
                  wr_en  = 1'b1;
                  accept = 1'b1;
               end else begin
                  drop = 1'b1;
               end
            end
            // A pixel in the same cycle as clear_in is still written; the sweep follows.
            if (clear_in) begin
               state_nxt      = CLEAR;
               clear_addr_nxt = '0;
            end
         end
         CLEAR: begin
            wr_en   = 1'b1;
            wr_addr = clear_addr;
            wr_data = CLEAR_INDEX;
            drop    = pix_valid_in;
            if (clear_addr == LAST_ADDR) begin
               state_nxt      = IDLE;
               clear_addr_nxt = '0;
            end else begin
               clear_addr_nxt = clear_addr + 16'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign clearing_out = (state == CLEAR);

   // Accepted-write counter (wraps) and dropped-write counter (saturates)
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         write_count_out <= '0;
         drop_count_out  <= '0;
      end else begin
         if (accept) write_count_out <= write_count_out + 32'd1;
         if (drop && drop_count_out != 16'hFFFF) drop_count_out <= drop_count_out + 16'd1;
      end
   end

   // Port A: write side of the frame store
   // NOTE: the RAM array has no reset; its contents persist through rst_in and are set only by writes.
   always_ff @(posedge clk_in) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Port B: registered read, returns old data on a same-address write
   always_ff @(posedge clk_in) begin
      rd_data <= mem[rd_addr];
   end

   // Display pipe: S1 scale, S2 address, S3 RAM read, S4 colour map plus sync delay
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         s1_x      <= '0;
         s1_y      <= '0;
         s1_vis    <= 1'b0;
         s2_vis    <= 1'b0;
         s3_vis    <= 1'b0;
         rd_addr   <= '0;
         rgb_out   <= '0;
         hsync_sr  <= '0;
         vsync_sr  <= '0;
         active_sr <= '0;
      end else begin
         s1_x   <= hcount_in[10:SCALE_LOG2];
         s1_y   <= vcount_in[9:SCALE_LOG2];
         s1_vis <= (hcount_in < H_ACTIVE) && (vcount_in < V_ACTIVE) && active_draw_in;

         // Out-of-picture coordinates read address 0; the result is blanked anyway.
         rd_addr <= s1_vis ? (16'(s1_y) * WIDTH_W + 16'(s1_x)) : '0;
         s2_vis  <= s1_vis;

         s3_vis <= s2_vis;

         if (!s3_vis)                     rgb_out <= '0;
         else if (rd_data == STAFF_INDEX) rgb_out <= STAFF_RGB;
         else                             rgb_out <= {rd_data, rd_data, rd_data};

         hsync_sr  <= {hsync_sr[2:0], hsync_in};
         vsync_sr  <= {vsync_sr[2:0], vsync_in};
         active_sr <= {active_sr[2:0], active_draw_in};
      end
   end

   assign hsync_out       = hsync_sr[3];
   assign vsync_out       = vsync_sr[3];
   assign active_draw_out = active_sr[3];

endmodule

// File: tb/tb_staff_frame_buffer.sv
// tb_staff_frame_buffer: self-checking bench for staff_frame_buffer.
// It holds a byte-array image of the frame store and derives the expected
// pixel colours from the raster coordinates.
module tb_staff_frame_buffer;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic [15:0] pix_addr_in = '0;
   logic [15:0] pix_data_in = '0;
   logic        pix_valid_in = 1'b0;
   logic        clear_in = 1'b0;
   logic [10:0] hcount_in = '0;
   logic [9:0]  vcount_in = '0;
   logic        active_draw_in = 1'b0;
   logic        hsync_in = 1'b0;
   logic        vsync_in = 1'b0;
   logic [23:0] rgb_out;
   logic        active_draw_out;
   logic        hsync_out;
   logic        vsync_out;
   logic        clearing_out;
   logic [15:0] drop_count_out;
   logic [31:0] write_count_out;

   staff_frame_buffer dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .pix_addr_in     (pix_addr_in),
      .pix_data_in     (pix_data_in),
      .pix_valid_in    (pix_valid_in),
      .clear_in        (clear_in),
      .hcount_in       (hcount_in),
      .vcount_in       (vcount_in),
      .active_draw_in  (active_draw_in),
      .hsync_in        (hsync_in),
      .vsync_in        (vsync_in),
      .rgb_out         (rgb_out),
      .active_draw_out (active_draw_out),
      .hsync_out       (hsync_out),
      .vsync_out       (vsync_out),
      .clearing_out    (clearing_out),
      .drop_count_out  (drop_count_out),
      .write_count_out (write_count_out)
   );

   always #5 clk_in = ~clk_in;

   int vectors = 0;
   int miscompares = 0;

   // Reference image of the frame store plus expected counters
   logic [7:0] model_mem [0:57599];
   int         model_wc = 0;
   int         model_dc = 0;

   typedef struct {
      logic [10:0] h;
      logic [9:0]  v;
      logic        act;
      logic [23:0] rgb;
   } vec_t;

   localparam int NT = 18;
   vec_t table_v [NT];

   localparam int NR = 3000;
   logic [10:0] rh [NR];
   logic [9:0]  rv [NR];
   logic        ract [NR];
   logic        rhs [NR];
   logic        rvs [NR];
   logic [23:0] exp_rgb [NR];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Advance one clock; inputs and outputs are handled 1 ns after the edge.
   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // Pixel colour for a raster position, from the image and scaling rules
   function automatic logic [23:0] model_rgb(input int h, input int v, input logic a);
      logic [7:0] idx;
      if (!a || h >= 1280 || v >= 720) return 24'h000000;
      idx = model_mem[(v / 4) * 320 + (h / 4)];
      if (idx == 8'h94) return 24'h949494;
      return {idx, idx, idx};
   endfunction

   task automatic model_write(input int addr, input logic [15:0] data);
      if (addr < 57600) begin
         model_mem[addr] = data[7:0];
         model_wc++;
      end else if (model_dc < 65535) begin
         model_dc++;
      end
   endtask

   task automatic write_pix(input logic [15:0] addr, input logic [15:0] data);
      pix_addr_in  = addr;
      pix_data_in  = data;
      pix_valid_in = 1'b1;
      step();
      pix_valid_in = 1'b0;
      model_write(int'(addr), data);
   endtask

   // Hold one raster position for the pipe depth, then compare the colour
   task automatic read_px(input string name, input logic [10:0] h, input logic [9:0] v,
                          input logic a, input logic [23:0] exp);
      hcount_in      = h;
      vcount_in      = v;
      active_draw_in = a;
      repeat (4) step();
      check(name, 32'(rgb_out), 32'(exp));
   endtask

   initial begin
      int cnt;

      table_v[0]  = '{11'd0,    10'd0,   1'b1, 24'h000000};
      table_v[1]  = '{11'd3,    10'd3,   1'b1, 24'h000000};
      table_v[2]  = '{11'd1279, 10'd719, 1'b1, 24'h404040};
      table_v[3]  = '{11'd1276, 10'd716, 1'b1, 24'h404040};
      table_v[4]  = '{11'd1275, 10'd716, 1'b1, 24'hFFFFFF};
      table_v[5]  = '{11'd4,    10'd4,   1'b1, 24'h949494};
      table_v[6]  = '{11'd7,    10'd7,   1'b1, 24'h949494};
      table_v[7]  = '{11'd5,    10'd6,   1'b1, 24'h949494};
      table_v[8]  = '{11'd6,    10'd5,   1'b1, 24'h949494};
      table_v[9]  = '{11'd8,    10'd4,   1'b1, 24'hFFFFFF};
      table_v[10] = '{11'd3,    10'd4,   1'b1, 24'hFFFFFF};
      table_v[11] = '{11'd4,    10'd8,   1'b1, 24'hFFFFFF};
      table_v[12] = '{11'd1280, 10'd0,   1'b1, 24'h000000};
      table_v[13] = '{11'd0,    10'd720, 1'b1, 24'h000000};
      table_v[14] = '{11'd1649, 10'd749, 1'b1, 24'h000000};
      table_v[15] = '{11'd4,    10'd4,   1'b0, 24'h000000};
      table_v[16] = '{11'd100,  10'd100, 1'b1, 24'hFFFFFF};
      table_v[17] = '{11'd1279, 10'd0,   1'b1, 24'hFFFFFF};

      // Reset state
      repeat (3) step();
      check("reset rgb", 32'(rgb_out), 32'h0);
      check("reset hsync", 32'(hsync_out), 32'h0);
      check("reset vsync", 32'(vsync_out), 32'h0);
      check("reset active", 32'(active_draw_out), 32'h0);
      check("reset clearing", 32'(clearing_out), 32'h0);
      check("reset drops", 32'(drop_count_out), 32'h0);
      check("reset writes", write_count_out, 32'h0);
      rst_in = 1'b1;
      step();

      // Full clear sweep: 10 pixel writes dropped, one ignored re-trigger
      clear_in = 1'b1;
      step();
      clear_in = 1'b0;
      check("clearing rises", 32'(clearing_out), 32'h1);
      cnt = 0;
      for (int i = 0; i < 60000; i++) begin
         if (!clearing_out) break;
         cnt++;
         pix_valid_in = (i < 10);
         pix_addr_in  = 16'(i);
         clear_in     = (i == 100);
         step();
      end
      pix_valid_in = 1'b0;
      clear_in     = 1'b0;
      check("sweep length", 32'(cnt), 32'd57600);
      check("sweep drops", 32'(drop_count_out), 32'd10);
      check("sweep writes", write_count_out, 32'd0);
      for (int a = 0; a < 57600; a++) model_mem[a] = 8'hFF;
      model_dc = 10;

      // Directed writes, including an out-of-range address
      write_pix(16'd0, 16'hAB00);
      write_pix(16'd57599, 16'h0040);
      write_pix(16'd321, 16'h1294);
      check("writes after 3", write_count_out, 32'd3);
      write_pix(16'hE100, 16'h0077);
      check("oob drop", 32'(drop_count_out), 32'd11);
      check("oob writes", write_count_out, 32'd3);

      // Table-driven raster reads
      for (int t = 0; t < NT; t++)
         read_px($sformatf("table[%0d]", t), table_v[t].h, table_v[t].v, table_v[t].act,
                 table_v[t].rgb);

      // Random raster stream with concurrent writes (same-address collisions included)
      for (int j = 0; j < NR + 4; j++) begin
         if (j >= 4) begin
            check($sformatf("rand rgb[%0d]", j - 4), 32'(rgb_out), 32'(exp_rgb[j-4]));
            check("rand hsync", 32'(hsync_out), 32'(rhs[j-4]));
            check("rand vsync", 32'(vsync_out), 32'(rvs[j-4]));
            check("rand active", 32'(active_draw_out), 32'(ract[j-4]));
         end
         if (j < NR) begin
            if ($urandom_range(0, 3) != 0) begin
               rh[j] = 11'($urandom_range(0, 31));
               rv[j] = 10'($urandom_range(0, 31));
            end else begin
               rh[j] = 11'($urandom_range(0, 1649));
               rv[j] = 10'($urandom_range(0, 749));
            end
            ract[j] = ($urandom_range(0, 7) != 0);
            rhs[j]  = 1'($urandom_range(0, 1));
            rvs[j]  = 1'($urandom_range(0, 1));
            hcount_in      = rh[j];
            vcount_in      = rv[j];
            active_draw_in = ract[j];
            hsync_in       = rhs[j];
            vsync_in       = rvs[j];
            pix_valid_in   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) pix_addr_in = 16'($urandom_range(0, 65535));
            else pix_addr_in = 16'($urandom_range(0, 7) * 320 + $urandom_range(0, 7));
            pix_data_in = 16'($urandom);
            if (pix_valid_in) model_write(int'(pix_addr_in), pix_data_in);
         end else begin
            pix_valid_in = 1'b0;
         end
         // The read for sample j-1 sees writes up to and including cycle j, not later.
         if (j >= 1 && j - 1 < NR) exp_rgb[j-1] = model_rgb(int'(rh[j-1]), int'(rv[j-1]), ract[j-1]);
         step();
      end
      check("rand writes", write_count_out, 32'(model_wc));
      check("rand drops", 32'(drop_count_out), 32'(model_dc));
      hsync_in = 1'b0;
      vsync_in = 1'b0;

      // Reset in the middle of a sweep, after address 999 has been cleared
      write_pix(16'd1000, 16'h0012);
      write_pix(16'd999, 16'h0034);
      pix_addr_in  = 16'd2000;
      pix_data_in  = 16'h0055;
      pix_valid_in = 1'b1;
      clear_in     = 1'b1;
      step();
      pix_valid_in = 1'b0;
      clear_in     = 1'b0;
      model_mem[2000] = 8'h55;
      model_wc++;
      check("clear+pixel write", write_count_out, 32'(model_wc));
      check("clear+pixel clearing", 32'(clearing_out), 32'h1);
      repeat (1000) step();
      rst_in = 1'b0;
      #1;
      check("abort clearing", 32'(clearing_out), 32'h0);
      check("abort drops", 32'(drop_count_out), 32'h0);
      check("abort writes", write_count_out, 32'h0);
      check("abort rgb", 32'(rgb_out), 32'h0);
      for (int a = 0; a < 1000; a++) model_mem[a] = 8'hFF;
      step();
      rst_in = 1'b1;
      repeat (3) step();
      check("idle after release", 32'(clearing_out), 32'h0);
      read_px("addr 999 cleared", 11'd156, 10'd12, 1'b1, model_rgb(156, 12, 1'b1));
      read_px("addr 1000 kept", 11'd160, 10'd12, 1'b1, 24'h121212);
      read_px("addr 2000 kept", 11'd320, 10'd24, 1'b1, 24'h555555);
      read_px("addr 57599 kept", 11'd1276, 10'd716, 1'b1, model_rgb(1276, 716, 1'b1));
      write_pix(16'd5, 16'h0077);
      check("write after abort", write_count_out, 32'd1);
      read_px("addr 5 new", 11'd20, 10'd0, 1'b1, 24'h777777);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
